// File: rtl/datapath_pipe.sv
// Three-stage (READ -> EXEC -> WB) datapath: register file, operand latches, barrel shifter,
// ALU, result register C and NZCV flags, with full forwarding, stall and an external write port.
module datapath_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS),
  parameter int SHW    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [AW-1:0]     a_addr,
  input  logic [AW-1:0]     b_addr,
  input  logic [AW-1:0]     s_addr,
  input  logic              sel_a,
  input  logic              sel_b,
  input  logic              sel_shift,
  input  logic [1:0]        shift_op,
  input  logic [SHW-1:0]    shift_imme,
  input  logic [DATA_W-1:0] imme_data,
  input  logic [2:0]        alu_op,
  input  logic              en_status,
  input  logic              w_en,
  input  logic [AW-1:0]     w_addr,
  input  logic              stall,
  input  logic              ext_w_en,
  input  logic [AW-1:0]     ext_w_addr,
  input  logic [DATA_W-1:0] ext_w_data,
  output logic [DATA_W-1:0] datapath_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] status_out
);

  localparam int MSB   = DATA_W - 1;
  localparam int AMT_W = (SHW + 1 > 8) ? SHW + 1 : 8;
  localparam logic [AMT_W-1:0] DW_AMT = AMT_W'(DATA_W);

  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_op_e;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_MOV, ALU_MVN, ALU_RSB
  } alu_op_e;

  logic [DATA_W-1:0] rf_q [NREGS];

  // READ/EXEC boundary
  logic              ex_valid_q;
  logic [DATA_W-1:0] a_q, b_q, imme_q;
  logic [7:0]        s_q;
  logic              sel_b_q, sel_shift_q, en_status_q, w_en_q;
  shift_op_e         shift_op_q;
  logic [SHW-1:0]    shift_imme_q;
  alu_op_e           alu_op_q;
  logic [AW-1:0]     w_addr_q;

  // EXEC/WB boundary
  logic              wb_valid_q;
  logic [AW-1:0]     wb_addr_q;
  logic [DATA_W-1:0] c_q, c_d;
  logic              out_valid_q;
  logic [3:0]        nzcv_q, nzcv_d;

  // ---------------- READ: operand selection with forwarding ----------------
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [AW-1:0] addr,
    input logic ex_en, input logic [AW-1:0] ex_addr, input logic [DATA_W-1:0] ex_val,
    input logic wb_en, input logic [AW-1:0] wb_addr, input logic [DATA_W-1:0] wb_val,
    input logic xt_en, input logic [AW-1:0] xt_addr, input logic [DATA_W-1:0] xt_val,
    input logic [DATA_W-1:0] rf_val
  );
    if (ex_en && addr == ex_addr) return ex_val;
    if (wb_en && addr == wb_addr) return wb_val;
    if (xt_en && addr == xt_addr) return xt_val;
    return rf_val;
  endfunction

  logic              ex_fwd_en;
  logic [DATA_W-1:0] fwd_a, fwd_b, fwd_s;

  assign ex_fwd_en = ex_valid_q && w_en_q;
  assign fwd_a = pick_operand(a_addr, ex_fwd_en, w_addr_q, c_d, wb_valid_q, wb_addr_q, c_q,
                              ext_w_en, ext_w_addr, ext_w_data, rf_q[a_addr]);
  assign fwd_b = pick_operand(b_addr, ex_fwd_en, w_addr_q, c_d, wb_valid_q, wb_addr_q, c_q,
                              ext_w_en, ext_w_addr, ext_w_data, rf_q[b_addr]);
  assign fwd_s = pick_operand(s_addr, ex_fwd_en, w_addr_q, c_d, wb_valid_q, wb_addr_q, c_q,
                              ext_w_en, ext_w_addr, ext_w_data, rf_q[s_addr]);

  // ---------------- EXEC: barrel shifter ----------------
  logic [AMT_W-1:0]  amt;
  logic [SHW-1:0]    rot;
  logic [SHW:0]      rot_inv;
  logic [DATA_W-1:0] shifted, b_op;

  assign amt     = sel_shift_q ? AMT_W'(s_q) : AMT_W'(shift_imme_q);
  assign rot     = amt[SHW-1:0];
  assign rot_inv = (SHW + 1)'(DATA_W) - {1'b0, rot};

  always_comb begin
    shifted = b_q;
    case (shift_op_q)
      SH_LSL: shifted = (amt >= DW_AMT) ? '0 : (b_q << amt);
      SH_LSR: shifted = (amt >= DW_AMT) ? '0 : (b_q >> amt);
      SH_ASR: shifted = (amt >= DW_AMT) ? {DATA_W{b_q[MSB]}} : DATA_W'($signed(b_q) >>> amt);
      // rot_inv == DATA_W when rot == 0, so the left half shifts out to zero.
      SH_ROR: shifted = (b_q >> rot) | (b_q << rot_inv);
      default: shifted = b_q;
    endcase
  end

  assign b_op = sel_b_q ? imme_q : shifted;

  // ---------------- EXEC: ALU and flags ----------------
  logic              arith, cin, ovf;
  logic [DATA_W-1:0] x, y;
  logic [DATA_W:0]   sum;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned
  // and infer a latch.
  always_comb begin
    arith = 1'b0;
    x     = a_q;
    y     = b_op;
    cin   = 1'b0;
    case (alu_op_q)
      ALU_ADD: arith = 1'b1;
      ALU_SUB: begin arith = 1'b1; y = ~b_op; cin = 1'b1; end
      ALU_RSB: begin arith = 1'b1; x = b_op; y = ~a_q; cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
  assign ovf = (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]);

  always_comb begin
    c_d = sum[DATA_W-1:0];
    case (alu_op_q)
      ALU_AND: c_d = a_q & b_op;
      ALU_ORR: c_d = a_q | b_op;
      ALU_EOR: c_d = a_q ^ b_op;
      ALU_MOV: c_d = b_op;
      ALU_MVN: c_d = ~b_op;
      default: ;
    endcase
  end

  assign nzcv_d = {c_d[MSB], (c_d == '0),
                   arith ? sum[DATA_W] : nzcv_q[1],
                   arith ? ovf         : nzcv_q[0]};

  // ---------------- pipeline registers ----------------
  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      s_q          <= '0;
      imme_q       <= '0;
      sel_b_q      <= 1'b0;
      sel_shift_q  <= 1'b0;
      shift_op_q   <= SH_LSL;
      shift_imme_q <= '0;
      alu_op_q     <= ALU_ADD;
      en_status_q  <= 1'b0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      c_q          <= '0;
      out_valid_q  <= 1'b0;
      nzcv_q       <= '0;
    end else if (stall) begin
      out_valid_q <= 1'b0;
    end else begin
      ex_valid_q <= issue_valid;
      if (issue_valid) begin
        a_q          <= sel_a ? '0 : fwd_a;
        b_q          <= fwd_b;
        s_q          <= fwd_s[7:0];
        imme_q       <= imme_data;
        sel_b_q      <= sel_b;
        sel_shift_q  <= sel_shift;
        shift_op_q   <= shift_op_e'(shift_op);
        shift_imme_q <= shift_imme;
        alu_op_q     <= alu_op_e'(alu_op);
        en_status_q  <= en_status;
        w_en_q       <= w_en;
        w_addr_q     <= w_addr;
      end
      out_valid_q <= ex_valid_q;
      wb_valid_q  <= ex_valid_q && w_en_q;
      if (ex_valid_q) begin
        c_q       <= c_d;
        wb_addr_q <= w_addr_q;
        if (en_status_q) nzcv_q <= nzcv_d;
      end
    end
  end

  // ---------------- register file ----------------
  // NOTE: the register file is explicitly cleared on reset because software relies on
  // every entry reading 0 afterwards; the WB write is placed last so it wins an address clash.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      if (ext_w_en) rf_q[ext_w_addr] <= ext_w_data;
      if (!stall && wb_valid_q) rf_q[wb_addr_q] <= c_q;
    end
  end

  assign datapath_out = c_q;
  assign out_valid    = out_valid_q && !stall;
  assign status_out   = {nzcv_q, {(DATA_W-4){1'b0}}};

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: stimulus pushes hand-computed results into a queue,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_datapath_pipe;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int SHW = 5;

  localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, ORR = 3'd3,
                         EOR = 3'd4, MOV = 3'd5, MVN = 3'd6, RSB = 3'd7;

  logic           clk = 1'b0;
  logic           rst_n, issue_valid, sel_a, sel_b, sel_shift, en_status, w_en, stall, ext_w_en;
  logic [AW-1:0]  a_addr, b_addr, s_addr, w_addr, ext_w_addr;
  logic [1:0]     shift_op;
  logic [SHW-1:0] shift_imme;
  logic [DW-1:0]  imme_data, ext_w_data, datapath_out, status_out;
  logic [2:0]     alu_op;
  logic           out_valid;

  datapath_pipe #(.DATA_W(DW), .NREGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .a_addr(a_addr), .b_addr(b_addr), .s_addr(s_addr),
    .sel_a(sel_a), .sel_b(sel_b), .sel_shift(sel_shift),
    .shift_op(shift_op), .shift_imme(shift_imme), .imme_data(imme_data),
    .alu_op(alu_op), .en_status(en_status), .w_en(w_en), .w_addr(w_addr),
    .stall(stall), .ext_w_en(ext_w_en), .ext_w_addr(ext_w_addr), .ext_w_data(ext_w_data),
    .datapath_out(datapath_out), .out_valid(out_valid), .status_out(status_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] s;
    int            tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented result against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, expected no output", datapath_out);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("op%0d_data", e.tag), datapath_out, e.d);
        check($sformatf("op%0d_status", e.tag), status_out, e.s);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(
    input logic sa, input logic [AW-1:0] a, input logic sb, input logic [AW-1:0] b,
    input logic ss, input logic [AW-1:0] s, input logic [1:0] sop, input logic [SHW-1:0] simm,
    input logic [DW-1:0] imm, input logic [2:0] aop, input logic est,
    input logic we, input logic [AW-1:0] wa,
    input bit push, input logic [DW-1:0] exp_d, input logic [DW-1:0] exp_s
  );
    exp_t e;
    issue_valid = 1'b1;
    sel_a = sa; a_addr = a; sel_b = sb; b_addr = b;
    sel_shift = ss; s_addr = s; shift_op = sop; shift_imme = simm;
    imme_data = imm; alu_op = aop; en_status = est; w_en = we; w_addr = wa;
    if (push) begin
      e.d = exp_d; e.s = exp_s; e.tag = tag_n;
      tag_n++;
      exp_q.push_back(e);
    end
    step();
    issue_valid = 1'b0;
  endtask

  // MOV of a register through LSL #0 with flags untouched.
  task automatic read_reg(input logic [AW-1:0] r, input logic [DW-1:0] exp_d,
                          input logic [DW-1:0] exp_s);
    issue_op(1'b1, 4'd0, 1'b0, r, 1'b0, 4'd0, LSL, 5'd0, '0, MOV, 1'b0, 1'b0, 4'd0,
             1'b1, exp_d, exp_s);
  endtask

  task automatic ext_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ext_w_en = 1'b1; ext_w_addr = addr; ext_w_data = data;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; stall = 1'b0; ext_w_en = 1'b0;
    sel_a = 1'b0; sel_b = 1'b0; sel_shift = 1'b0; en_status = 1'b0; w_en = 1'b0;
    a_addr = '0; b_addr = '0; s_addr = '0; w_addr = '0; ext_w_addr = '0;
    shift_op = '0; shift_imme = '0; imme_data = '0; ext_w_data = '0; alu_op = '0;

    repeat (2) step();
    check("reset_out", datapath_out, 32'h0);
    check("reset_status", status_out, 32'h0);
    check("reset_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      ext_write(AW'(i), DW'(i));
      step();
    end
    ext_w_en = 1'b0;

    // r1 + (r2 LSL r1) = 1 + 4
    issue_op(0, 1, 0, 2, 1, 1, LSL, 0, 0, ADD, 1, 0, 0, 1, 32'd5, 32'h0);
    // 0 - 12
    issue_op(1, 0, 1, 0, 0, 0, LSL, 0, 12, SUB, 1, 0, 0, 1, 32'hFFFFFFF4, 32'h80000000);
    drain();

    // r0 = 0 - 12, then forwarded from EXEC, then from WB, then from the register file
    issue_op(1, 0, 1, 0, 0, 0, LSL, 0, 12, SUB, 1, 1, 0, 1, 32'hFFFFFFF4, 32'h80000000);
    issue_op(1, 0, 0, 0, 0, 0, LSL, 0, 0, SUB, 1, 0, 0, 1, 32'd12, 32'h0);
    read_reg(0, 32'hFFFFFFF4, 32'h0);
    read_reg(0, 32'hFFFFFFF4, 32'h0);
    drain();

    // signed overflow, then shifter boundaries with r8 forwarded from the ext port
    ext_write(7, 32'h7FFFFFFF);
    step();
    ext_w_en = 1'b0;
    issue_op(0, 7, 0, 1, 0, 0, LSL, 0, 0, ADD, 1, 0, 0, 1, 32'h80000000, 32'h90000000);
    ext_write(9, 32'd40);
    step();
    ext_write(8, 32'h80000000);
    issue_op(1, 0, 0, 8, 1, 9, ASR, 0, 0, MOV, 1, 0, 0, 1, 32'hFFFFFFFF, 32'h90000000);
    ext_w_en = 1'b0;
    issue_op(1, 0, 0, 8, 1, 9, LSR, 0, 0, MOV, 0, 0, 0, 1, 32'h0, 32'h90000000);
    issue_op(1, 0, 0, 8, 1, 9, ROR, 0, 0, MOV, 0, 0, 0, 1, 32'h00800000, 32'h90000000);
    issue_op(0, 8, 0, 8, 0, 0, LSL, 0, 0, ADD, 1, 0, 0, 1, 32'h0, 32'h70000000);
    issue_op(0, 3, 0, 2, 0, 0, LSL, 0, 0, RSB, 1, 0, 0, 1, 32'hFFFFFFFF, 32'h80000000);
    issue_op(1, 0, 0, 3, 0, 0, LSL, 4, 0, MOV, 0, 0, 0, 1, 32'h30, 32'h80000000);
    issue_op(0, 6, 0, 3, 0, 0, LSL, 0, 0, AND, 0, 0, 0, 1, 32'h2, 32'h80000000);
    issue_op(0, 6, 0, 3, 0, 0, LSL, 0, 0, ORR, 0, 0, 0, 1, 32'h7, 32'h80000000);
    issue_op(0, 6, 0, 3, 0, 0, LSL, 0, 0, EOR, 0, 0, 0, 1, 32'h5, 32'h80000000);
    issue_op(1, 0, 0, 0, 0, 0, LSL, 0, 0, MVN, 0, 0, 0, 1, 32'hB, 32'h80000000);
    drain();

    // stall three cycles with an op in EXEC; issue during stall must be ignored
    issue_op(0, 1, 0, 2, 0, 0, LSL, 0, 0, ADD, 1, 1, 10, 1, 32'd3, 32'h0);
    stall = 1'b1;
    ext_write(12, 32'hABCD);
    issue_valid = 1'b1; sel_a = 1'b1; sel_b = 1'b1; imme_data = 32'hDEAD;
    alu_op = MOV; en_status = 1'b1; w_en = 1'b1; w_addr = 4'd13;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_valid", i), out_valid, 1'b0);
      check($sformatf("stall%0d_out", i), datapath_out, 32'hB);
      check($sformatf("stall%0d_status", i), status_out, 32'h80000000);
      step();
      ext_w_en = 1'b0;
    end
    stall = 1'b0;
    issue_valid = 1'b0;
    drain();
    read_reg(10, 32'd3, 32'h0);
    read_reg(12, 32'hABCD, 32'h0);
    read_reg(13, 32'd13, 32'h0);
    drain();

    // WB and ext write to the same register: WB wins
    issue_op(1, 0, 1, 0, 0, 0, LSL, 0, 32'h55, MOV, 0, 1, 5, 1, 32'h55, 32'h0);
    step();
    ext_write(5, 32'h99);
    step();
    ext_w_en = 1'b0;
    read_reg(5, 32'h55, 32'h0);
    // WB and ext write to different registers: both land
    issue_op(1, 0, 1, 0, 0, 0, LSL, 0, 32'h66, MOV, 0, 1, 14, 1, 32'h66, 32'h0);
    step();
    ext_write(6, 32'h77);
    step();
    ext_w_en = 1'b0;
    read_reg(14, 32'h66, 32'h0);
    read_reg(6, 32'h77, 32'h0);
    drain();

    // reset with an op in flight: discarded, no writeback, everything cleared
    issue_op(1, 0, 1, 0, 0, 0, LSL, 0, 32'h1234, MOV, 0, 1, 15, 0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (2) step();
    check("midreset_out", datapath_out, 32'h0);
    check("midreset_status", status_out, 32'h0);
    check("midreset_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    step();
    read_reg(15, 32'h0, 32'h0);
    read_reg(5, 32'h0, 32'h0);
    read_reg(1, 32'h0, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
